adc_spi_reader: RTL and testbench

- Periodically runs one SPI conversion frame on the Pmod ADC (12-bit, CS-framed, 16 SCLK per frame, 4 leading zeros, MSB first).
- Right-justifies the sample into a 16-bit word.
- Presents the word with a one-cycle ready pulse.
- Sits directly upstream of the 16-bit shift-out/latch stage: data_o/data_rdy_o connect straight to its data_i/data_rdy_i, and that stage starts on the rising edge of data_rdy_i.

---
 rtl/adc_spi_reader_pkg.sv | 30 +++
 rtl/adc_spi_reader_if.sv | 36 +++
 rtl/adc_spi_reader_tick_gen.sv | 43 ++++
 rtl/adc_spi_reader.sv | 185 ++++++++++++++++++
 tb/tb_adc_spi_reader.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared types and constants for the Pmod ADC SPI reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_e;

    localparam int FRAME_BITS  = 16;   // SCLK periods per CS frame
    localparam int SAMPLE_BITS = 12;   // converter resolution
    localparam int LEAD_ZEROS  = 4;    // leading bits discarded from a frame
    localparam int OUT_WIDTH   = 16;   // width of the presented word
    localparam int BIT_CNT_W   = $clog2(FRAME_BITS + 1);

    // Keeps only the sample field of a raw frame
    localparam logic [FRAME_BITS-1:0] SAMPLE_MASK =
        {{LEAD_ZEROS{1'b0}}, {SAMPLE_BITS{1'b1}}};

endpackage
`default_nettype wire

// File: rtl/adc_spi_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader_if
//  Description : SPI pins of the ADC plus the word/ready pair handed to the
//                downstream shift-out stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_spi_reader_if;
    import adc_pkg::*;

    logic                 adc_cs_no;
    logic                 adc_sclk_o;
    logic                 adc_miso_i;
    logic [OUT_WIDTH-1:0] data_o;
    logic                 data_rdy_o;

    // Reader side: drives the SPI master pins and the result word
    modport master (
        output adc_cs_no,
        output adc_sclk_o,
        output data_o,
        output data_rdy_o,
        input  adc_miso_i
    );

    // ADC / consumer side
    modport slave (
        input  adc_cs_no,
        input  adc_sclk_o,
        input  data_o,
        input  data_rdy_o,
        output adc_miso_i
    );

endinterface
`default_nettype wire

// File: rtl/adc_spi_reader_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Modulo-N counter; wrap_o is high on the count N-1 cycle.
//                clear_i forces the count back to 0 on the next edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int N = 4
) (
    input  wire logic clk_i,
    input  wire logic reset_ni,
    input  wire logic clear_i,
    output logic      wrap_o
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign wrap_o = (cnt_q == LAST);

    // Next count: clear wins, otherwise wrap at N-1
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || wrap_o) begin
            cnt_d = '0;
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : adc_spi_reader
//  Description : Periodically reads one 16-SCLK frame from the Pmod ADC,
//                right-justifies the 12-bit sample and presents it with a
//                one-cycle ready pulse.
//                Optional macro ADC_SPI_AVG4_EN: output the truncated mean
//                of four consecutive conversions instead of every sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_spi_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  wire logic          clk_i,
    input  wire logic          reset_ni,
    input  wire logic          enable_i,
    adc_spi_reader_if.master   bus,
    output logic               busy_o,
    output logic               overrun_o
);

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic                   rdy_q, rdy_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic                   overrun_q, overrun_d;
    logic                   period_tick;
    logic                   phase_wrap;
    logic                   state_change;
    logic                   done_entry;
    logic [FRAME_BITS-1:0]  raw_sample;

`ifdef ADC_SPI_AVG4_EN
    localparam int ACC_W = SAMPLE_BITS + 2;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       fcnt_q, fcnt_d;
    logic [ACC_W-1:0] sum;
`endif

    // Conversion start pacing; runs regardless of enable_i
    tick_gen #(.N(SAMPLE_PERIOD)) u_period (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (1'b0),
        .wrap_o   (period_tick)
    );

    // SCLK half-period timing, restarted on every state transition
    tick_gen #(.N(CLK_DIV)) u_phase (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clear_i  (state_change),
        .wrap_o   (phase_wrap)
    );

    assign state_change = (state_d != state_q);
    assign done_entry   = (state_d == DONE);
    assign raw_sample   = shreg_q & SAMPLE_MASK;

    // Frame sequencer next-state and shift/bit-count logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        case (state_q)
            IDLE: begin
                if (period_tick && enable_i) begin
                    state_d   = SETUP;
                    bit_cnt_d = '0;
                end
            end
            SETUP: begin
                if (phase_wrap) state_d = LOW;
            end
            LOW: begin
                if (phase_wrap) state_d = HIGH;
            end
            HIGH: begin
                if (phase_wrap) begin
                    // Last cycle before SCLK falls: capture MISO
                    shreg_d   = {shreg_q[FRAME_BITS-2:0], bus.adc_miso_i};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_d == BIT_CNT_W'(FRAME_BITS)) ? HOLD : LOW;
                end
            end
            HOLD: begin
                if (phase_wrap) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pin levels, overrun flag and result word, derived from the next state
    always_comb begin
        cs_n_d    = !((state_d == SETUP) || (state_d == LOW) || (state_d == HIGH));
        sclk_d    = (state_d != LOW);
        overrun_d = overrun_q | (period_tick && (state_q != IDLE));
        data_d    = data_q;
        rdy_d     = 1'b0;
`ifdef ADC_SPI_AVG4_EN
        acc_d  = acc_q;
        fcnt_d = fcnt_q;
        sum    = acc_q + ACC_W'(raw_sample);
        if (done_entry) begin
            if (fcnt_q == 2'd3) begin
                data_d = {{LEAD_ZEROS{1'b0}}, sum[ACC_W-1:2]};
                rdy_d  = 1'b1;
                acc_d  = '0;
                fcnt_d = 2'd0;
            end else begin
                acc_d  = sum;
                fcnt_d = fcnt_q + 2'd1;
            end
        end
`else
        if (done_entry) begin
            data_d = raw_sample;
            rdy_d  = 1'b1;
        end
`endif
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset idles the SPI pins at once
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef ADC_SPI_AVG4_EN
    // Averaging accumulator and conversion counter
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_q  <= '0;
            fcnt_q <= 2'd0;
        end else begin
            acc_q  <= acc_d;
            fcnt_q <= fcnt_d;
        end
    end
`endif

    assign bus.adc_cs_no  = cs_n_q;
    assign bus.adc_sclk_o = sclk_q;
    assign bus.data_o     = data_q;
    assign bus.data_rdy_o = rdy_q;
    assign busy_o         = (state_q != IDLE);
    assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_spi_reader
//  Description : Directed self-checking bench. Instance A uses the default
//                timing; instance B uses SAMPLE_PERIOD=100 to force overruns.
//                Each has a small ADC model that shifts a word out MSB first
//                on SCLK falling edges while CS is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_spi_reader;

    logic clk_i = 1'b0;
    logic reset_ni;
    logic enable_i;
    logic enable_b;
    logic busy_a, ovr_a, busy_b, ovr_b;

    always #5 clk_i = ~clk_i;

    adc_spi_reader_if bus_a ();
    adc_spi_reader_if bus_b ();

    adc_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(1000)) dut_a (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .enable_i  (enable_i),
        .bus       (bus_a),
        .busy_o    (busy_a),
        .overrun_o (ovr_a)
    );

    adc_spi_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(100)) dut_b (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .enable_i  (enable_b),
        .bus       (bus_b),
        .busy_o    (busy_b),
        .overrun_o (ovr_b)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Clock edges since the last reset release
    int cyc;
    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    // Instance A: ADC model and frame monitor
    logic [15:0] word_a;
    logic pcs_a = 1'b1, psclk_a = 1'b1, prdy_a = 1'b0;
    int idx_a = 0, falls_a = 0, rises_a = 0, cslow_a = 0, csfalls_a = 0;
    int csfall_cyc_a = 0, rdy_cnt_a = 0, rdy_cyc_a = 0, wide_a = 0, stray_a = 0;
    always @(negedge clk_i) begin
        pcs_a   <= bus_a.adc_cs_no;
        psclk_a <= bus_a.adc_sclk_o;
        prdy_a  <= bus_a.data_rdy_o;
        if (pcs_a && !bus_a.adc_cs_no) begin
            idx_a        <= 0;
            falls_a      <= 0;
            rises_a      <= 0;
            cslow_a      <= 1;
            csfalls_a    <= csfalls_a + 1;
            csfall_cyc_a <= cyc;
        end else if (!bus_a.adc_cs_no) begin
            cslow_a <= cslow_a + 1;
            if (psclk_a && !bus_a.adc_sclk_o) begin
                falls_a <= falls_a + 1;
                if (idx_a < 16) bus_a.adc_miso_i <= word_a[15-idx_a];
                idx_a <= idx_a + 1;
            end
            if (!psclk_a && bus_a.adc_sclk_o) rises_a <= rises_a + 1;
        end
        if (bus_a.adc_cs_no && (psclk_a != bus_a.adc_sclk_o)) stray_a <= stray_a + 1;
        if (bus_a.data_rdy_o) begin
            rdy_cnt_a <= rdy_cnt_a + 1;
            rdy_cyc_a <= cyc;
            if (prdy_a) wide_a <= wide_a + 1;
        end
    end

    // Instance B: ADC model and CS/ready counters
    logic [15:0] word_b;
    logic pcs_b = 1'b1, psclk_b = 1'b1;
    int idx_b = 0, csfalls_b = 0, csfall_cyc_b = 0, rdy_cnt_b = 0;
    always @(negedge clk_i) begin
        pcs_b   <= bus_b.adc_cs_no;
        psclk_b <= bus_b.adc_sclk_o;
        if (pcs_b && !bus_b.adc_cs_no) begin
            idx_b        <= 0;
            csfalls_b    <= csfalls_b + 1;
            csfall_cyc_b <= cyc;
        end else if (!bus_b.adc_cs_no && psclk_b && !bus_b.adc_sclk_o) begin
            if (idx_b < 16) bus_b.adc_miso_i <= word_b[15-idx_b];
            idx_b <= idx_b + 1;
        end
        if (bus_b.data_rdy_o) rdy_cnt_b <= rdy_cnt_b + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        int k = 0;
        while (cyc < t && k < 20000) begin
            step();
            k++;
        end
    endtask

    task automatic wait_rdy_a(input int n, input string tag);
        int k = 0;
        while (rdy_cnt_a < n && k < 6000) begin
            step();
            k++;
        end
        chk({tag, "_timeout"}, 32'(rdy_cnt_a >= n), 32'd1);
    endtask

    initial begin
        reset_ni = 1'b0;
        enable_i = 1'b1;
        enable_b = 1'b1;
        word_a   = 16'h0ABC;
        word_b   = 16'h0C3A;
        repeat (3) step();

        chk("rst_cs",      32'(bus_a.adc_cs_no),  32'd1);
        chk("rst_sclk",    32'(bus_a.adc_sclk_o), 32'd1);
        chk("rst_data",    32'(bus_a.data_o),     32'h0);
        chk("rst_rdy",     32'(bus_a.data_rdy_o), 32'd0);
        chk("rst_busy",    32'(busy_a),           32'd0);
        chk("rst_overrun", 32'(ovr_a),            32'd0);

        reset_ni = 1'b1;

        // Overrun: 100-cycle period against a 137-cycle frame
        wait_cyc(150);
        chk("b_ovr_before", 32'(ovr_b), 32'd0);
        wait_cyc(205);
        chk("b_ovr_after",  32'(ovr_b), 32'd1);
        wait_cyc(950);
        chk("b_csfalls",    32'(csfalls_b),    32'd5);
        chk("b_last_csfall",32'(csfall_cyc_b), 32'd900);
        chk("b_ovr_sticky", 32'(ovr_b),        32'd1);

`ifdef ADC_SPI_AVG4_EN
        chk("b_avg_data",   32'(bus_b.data_o), 32'h0C3A);
        // Four frames 0x100..0x103 averaged into a single pulse
        word_a = 16'h0100;
        for (int k = 1; k <= 3; k++) begin
            wait_cyc(1000 * k + 200);
            word_a = 16'h0100 + 16'(k);
        end
        chk("avg_no_pulse", 32'(rdy_cnt_a), 32'd0);
        chk("avg_no_data",  32'(bus_a.data_o), 32'h0);
        wait_rdy_a(1, "avg1");
        chk("avg1_data", 32'(bus_a.data_o), 32'h0101);
        chk("avg1_cyc",  32'(rdy_cyc_a),    32'd4136);
        // Four saturated frames, lead bits also set
        word_a = 16'hFFFF;
        wait_rdy_a(2, "avg2");
        chk("avg2_data", 32'(bus_a.data_o), 32'h0FFF);
        chk("avg2_cyc",  32'(rdy_cyc_a),    32'd8136);
        chk("avg_wide",  32'(wide_a),       32'd0);
`else
        chk("b_rdy_cnt",    32'(rdy_cnt_b),    32'd4);
        chk("b_data",       32'(bus_b.data_o), 32'h0C3A);

        // Basic frame
        wait_cyc(1050);
        chk("busy_mid", 32'(busy_a), 32'd1);
        wait_rdy_a(1, "basic");
        chk("basic_csfall", 32'(csfall_cyc_a), 32'd1000);
        chk("basic_rdycyc", 32'(rdy_cyc_a),    32'd1136);
        chk("basic_data",   32'(bus_a.data_o), 32'h0ABC);
        chk("basic_falls",  32'(falls_a),      32'd16);
        chk("basic_rises",  32'(rises_a),      32'd16);
        chk("basic_cslow",  32'(cslow_a),      32'd132);
        chk("basic_stray",  32'(stray_a),      32'd0);
        step();
        chk("basic_rdy_1cyc", 32'(bus_a.data_rdy_o), 32'd0);
        chk("basic_busy_end", 32'(busy_a),           32'd0);
        chk("basic_no_ovr",   32'(ovr_a),            32'd0);

        // Lead masking
        word_a = 16'hFABC;
        wait_rdy_a(2, "mask");
        chk("mask_data",   32'(bus_a.data_o), 32'h0ABC);
        chk("mask_rdycyc", 32'(rdy_cyc_a),    32'd2136);

        // Enable gating over three periods
        enable_i = 1'b0;
        wait_cyc(5500);
        chk("gate_csfalls", 32'(csfalls_a),       32'd2);
        chk("gate_rdy",     32'(rdy_cnt_a),       32'd2);
        chk("gate_cs",      32'(bus_a.adc_cs_no), 32'd1);
        chk("gate_hold",    32'(bus_a.data_o),    32'h0ABC);
        enable_i = 1'b1;
        word_a   = 16'h0123;
        wait_rdy_a(3, "resume");
        chk("resume_csfall", 32'(csfall_cyc_a), 32'd6000);
        chk("resume_data",   32'(bus_a.data_o), 32'h0123);

        // Reset after the 7th SCLK fall of the next frame
        word_a = 16'h0F0F;
        begin
            int k = 0;
            while (!(csfalls_a == 4 && falls_a >= 7) && k < 3000) begin
                step();
                k++;
            end
            chk("mid_timeout", 32'(csfalls_a == 4 && falls_a >= 7), 32'd1);
        end
        reset_ni = 1'b0;
        #1;
        chk("mid_cs",   32'(bus_a.adc_cs_no),  32'd1);
        chk("mid_sclk", 32'(bus_a.adc_sclk_o), 32'd1);
        chk("mid_data", 32'(bus_a.data_o),     32'h0);
        chk("mid_busy", 32'(busy_a),           32'd0);
        chk("mid_ovr_b",32'(ovr_b),            32'd0);
        step();
        step();
        reset_ni = 1'b1;
        wait_cyc(900);
        chk("mid_no_pulse", 32'(rdy_cnt_a), 32'd3);
        wait_rdy_a(4, "post_rst");
        chk("post_rst_data", 32'(bus_a.data_o), 32'h0F0F);
        chk("post_rst_cyc",  32'(rdy_cyc_a),    32'd1136);
        chk("wide_total",    32'(wide_a),       32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
